mcs4_axi_host: RTL and testbench

- Parametrised AXI4 burst master that drives the mcs4_sys AXI slave port from a bench or PS-side sequencer.
- Supersedes hand-driven AW/W/AR/R stimulus: bench issues whole-burst commands and streams data.
- Unlike current harnesses, the B channel is fully handled, responses are aggregated and reported, and hung transfers are caught by a watchdog.
- Used to load ROM images and dump RAM state through the mcs4_sys memory map.

---
 rtl/mcs4_axi_host_if.sv | 62 ++++++
 rtl/mcs4_axi_host.sv | 201 ++++++++++++++++++++
 tb/tb_mcs4_axi_host.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcs4_axi_host_if.sv
// AXI4 master-side bundle between mcs4_axi_host and the mcs4_sys slave port.
// Only the signals the host actually drives or consumes are carried.
interface mcs4_axi_host_if #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;

   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;

   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;

   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;

   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/mcs4_axi_host.sv
// Whole-burst AXI4 master: takes one command, runs AW/W/B or AR/R, then pulses done
// with the worst response seen; a watchdog aborts transfers that stop handshaking.
module mcs4_axi_host #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_LEN    = 256,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [7:0]            cmd_len_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_last_o,
   output logic                  done_o,
   output logic [1:0]            done_resp_o,
   mcs4_axi_host_if.master       m_axi
);

   localparam logic [2:0] AXSIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;
   localparam int         WDW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            len_q, len_d;
   logic                  write_q, write_d;
   logic [8:0]            cnt_q, cnt_d;
   logic [1:0]            acc_q, acc_d;
   logic [WDW-1:0]        wdog_q, wdog_d;

   logic                  hs;
   logic                  busy;
   logic                  bad_len;
   logic                  timeout_hit;

   function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         wdog_q  <= wdog_d;
      end
   end

   assign m_axi.awaddr  = addr_q;
   assign m_axi.awlen   = len_q;
   assign m_axi.awsize  = AXSIZE;
   assign m_axi.awburst = 2'b01;
   assign m_axi.wstrb   = '1;
   assign m_axi.araddr  = addr_q;
   assign m_axi.arlen   = len_q;
   assign m_axi.arsize  = AXSIZE;
   assign m_axi.arburst = 2'b01;

   assign bad_len     = int'({1'b0, cmd_len_i}) >= MAX_LEN;
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign timeout_hit = (TIMEOUT != 0) && (wdog_q == WDW'(TIMEOUT - 1));

   // Channel outputs are only live in their own state, so AW and W can never overlap.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      len_d         = len_q;
      write_d       = write_q;
      cnt_d         = cnt_q;
      acc_d         = acc_q;
      wdog_d        = wdog_q;
      hs            = 1'b0;
      cmd_ready_o   = 1'b0;
      wr_ready_o    = 1'b0;
      rd_valid_o    = 1'b0;
      rd_data_o     = '0;
      rd_last_o     = 1'b0;
      done_o        = 1'b0;
      done_resp_o   = 2'b00;
      m_axi.awvalid = 1'b0;
      m_axi.wvalid  = 1'b0;
      m_axi.wdata   = '0;
      m_axi.wlast   = 1'b0;
      m_axi.bready  = 1'b0;
      m_axi.arvalid = 1'b0;
      m_axi.rready  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cmd_ready_o = 1'b1;
            cnt_d       = '0;
            wdog_d      = '0;
            if (cmd_valid_i) begin
               addr_d  = cmd_addr_i;
               len_d   = cmd_len_i;
               write_d = cmd_write_i;
               if (bad_len) begin
                  acc_d   = 2'b10;
                  state_d = S_DONE;
               end else begin
                  state_d = cmd_write_i ? S_AW : S_AR;
               end
            end
         end
         S_AW: begin
            m_axi.awvalid = 1'b1;
            if (m_axi.awready) begin
               hs      = 1'b1;
               state_d = S_W;
            end
         end
         S_W: begin
            m_axi.wvalid = wr_valid_i;
            wr_ready_o   = m_axi.wready;
            m_axi.wdata  = wr_data_i;
            m_axi.wlast  = (cnt_q == {1'b0, len_q});
            if (wr_valid_i && m_axi.wready) begin
               hs    = 1'b1;
               cnt_d = cnt_q + 9'd1;
               if (cnt_q == {1'b0, len_q}) state_d = S_B;
            end
         end
         S_B: begin
            m_axi.bready = 1'b1;
            if (m_axi.bvalid) begin
               hs      = 1'b1;
               acc_d   = resp_max(acc_q, m_axi.bresp);
               state_d = S_DONE;
            end
         end
         S_AR: begin
            m_axi.arvalid = 1'b1;
            if (m_axi.arready) begin
               hs      = 1'b1;
               state_d = S_R;
            end
         end
         S_R: begin
            m_axi.rready = rd_ready_i;
            rd_valid_o   = m_axi.rvalid;
            rd_data_o    = m_axi.rdata;
            rd_last_o    = m_axi.rlast;
            if (m_axi.rvalid && rd_ready_i) begin
               hs    = 1'b1;
               cnt_d = cnt_q + 9'd1;
               acc_d = resp_max(acc_q, m_axi.rresp);
               if (m_axi.rlast) begin
                  state_d = S_DONE;
                  // A slave that ends the burst early or late is reported as SLVERR.
                  if (cnt_q != {1'b0, len_q}) acc_d = resp_max(acc_d, 2'b10);
               end
            end
         end
         S_DONE: begin
            done_o      = 1'b1;
            done_resp_o = acc_q;
            acc_d       = '0;
            wdog_d      = '0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort leaves the slave wherever it was; this is a bench aid, not bus recovery.
      if (busy && (TIMEOUT != 0)) begin
         if (hs) begin
            wdog_d = '0;
         end else if (timeout_hit) begin
            wdog_d  = '0;
            acc_d   = 2'b11;
            state_d = S_DONE;
         end else begin
            wdog_d = wdog_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mcs4_axi_host.sv
// Bench for mcs4_axi_host: a small AXI memory slave plus scoreboard queues of
// expected read words and expected completion responses.
module tb_mcs4_axi_host;
   localparam int AW = 14;
   localparam int DW = 32;
   localparam int ML = 16;
   localparam int TO = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_len;
   logic          wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic          rd_valid, rd_ready, rd_last;
   logic [DW-1:0] rd_data;
   logic          done;
   logic [1:0]    done_resp;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] ref_mem [64];
   logic [31:0] smem [64];
   logic [31:0] wbuf [8];
   logic [31:0] exp_rd_q [$];
   logic [1:0]  exp_resp_q [$];

   always #5 clk = ~clk;

   mcs4_axi_host_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   mcs4_axi_host #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LEN(ML), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
      .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_last_o(rd_last),
      .done_o(done), .done_resp_o(done_resp),
      .m_axi(axi)
   );

   // Slave model: always-ready W, configurable AW/AR ready, optional error beat on R.
   logic       awready_en = 1'b1;
   logic       arready_en = 1'b1;
   int         err_beat = -1;
   bit         mem_init = 1'b0;
   logic [5:0] s_wptr, s_rptr, ridx;
   logic [7:0] s_rlen, s_rcnt;
   logic       s_bvalid, s_rvalid;

   assign axi.awready = awready_en;
   assign axi.arready = arready_en;
   assign axi.wready  = 1'b1;
   assign axi.bvalid  = s_bvalid;
   assign axi.bresp   = 2'b00;
   assign axi.rvalid  = s_rvalid;
   assign ridx        = s_rptr + s_rcnt[5:0];
   assign axi.rdata   = smem[ridx];
   assign axi.rlast   = (s_rcnt == s_rlen);
   assign axi.rresp   = (err_beat >= 0 && int'(s_rcnt) == err_beat) ? 2'b10 : 2'b00;

   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 64; i++) smem[i] <= 32'hC0DE_0000 | i;
         mem_init <= 1'b1;
      end
      if (rst) begin
         s_wptr <= '0; s_rptr <= '0; s_rlen <= '0; s_rcnt <= '0;
         s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      end else begin
         if (axi.awvalid && axi.awready) s_wptr <= axi.awaddr[7:2];
         if (axi.wvalid && axi.wready) begin
            smem[s_wptr] <= axi.wdata;
            s_wptr <= s_wptr + 6'd1;
            if (axi.wlast) s_bvalid <= 1'b1;
         end
         if (s_bvalid && axi.bready) s_bvalid <= 1'b0;
         if (axi.arvalid && axi.arready) begin
            s_rptr <= axi.araddr[7:2]; s_rlen <= axi.arlen;
            s_rcnt <= '0; s_rvalid <= 1'b1;
         end else if (s_rvalid && axi.rready) begin
            if (axi.rlast) s_rvalid <= 1'b0;
            else s_rcnt <= s_rcnt + 8'd1;
         end
      end
   end

   task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [7:0] l,
                            input logic [1:0] eresp);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
      exp_resp_q.push_back(eresp);
      #1;
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({cmd_ready, axi.awvalid, axi.wvalid, wr_ready, axi.bready, axi.arvalid,
           axi.rready, rd_valid, done, done_resp} !== {1'b1, 10'b0}) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %b required %b",
                  {cmd_ready, axi.awvalid, axi.wvalid, wr_ready, axi.bready, axi.arvalid,
                   axi.rready, rd_valid, done, done_resp}, {1'b1, 10'b0});
      end
      vectors++;
      if ({axi.awsize, axi.arsize, axi.awburst, axi.arburst, axi.wstrb} !==
          {3'd2, 3'd2, 2'b01, 2'b01, 4'hF}) begin
         miscompares++;
         $display("[TB] FAIL constants: got %h required %h",
                  {axi.awsize, axi.arsize, axi.awburst, axi.arburst, axi.wstrb},
                  {3'd2, 3'd2, 2'b01, 2'b01, 4'hF});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write(input logic [AW-1:0] a, input int len);
      int n;
      logic [5:0] idx;
      logic [1:0] er;
      issue_cmd(1'b1, a, len[7:0], 2'b00);
      wr_valid = 1'b1; wr_data = wbuf[0];
      #1;
      vectors++;
      if ({axi.awvalid, axi.awaddr, axi.awlen, axi.wvalid, wr_ready} !==
          {1'b1, a, len[7:0], 1'b0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL aw_phase: got %h required %h",
                  {axi.awvalid, axi.awaddr, axi.awlen, axi.wvalid, wr_ready},
                  {1'b1, a, len[7:0], 1'b0, 1'b0});
      end
      for (int i = 0; i <= len; i++) begin
         wr_valid = 1'b1; wr_data = wbuf[i];
         idx = a[7:2] + 6'(i);
         ref_mem[idx] = wbuf[i];
         #1;
         n = 0;
         while (!wr_ready && n < 50) begin @(negedge clk); n++; end
         vectors++;
         if ({wr_ready, axi.wvalid, axi.wlast, axi.wdata} !== {1'b1, 1'b1, (i == len), wbuf[i]}) begin
            miscompares++;
            $display("[TB] FAIL w_beat%0d: got %h required %h", i,
                     {wr_ready, axi.wvalid, axi.wlast, axi.wdata},
                     {1'b1, 1'b1, (i == len), wbuf[i]});
         end
         @(negedge clk);
      end
      wr_valid = 1'b0;
      n = 0;
      while (!done && n < 50) begin @(negedge clk); n++; end
      er = exp_resp_q.pop_front();
      vectors++;
      if ({done, done_resp} !== {1'b1, er}) begin
         miscompares++;
         $display("[TB] FAIL write_done: got %b required %b", {done, done_resp}, {1'b1, er});
      end
      @(negedge clk);
      vectors++;
      if ({done, cmd_ready} !== 2'b01) begin
         miscompares++;
         $display("[TB] FAIL write_done_pulse: got %b required 01", {done, cmd_ready});
      end
   endtask

   task automatic test_read(input logic [AW-1:0] a, input int len, input bit toggle,
                            input int ebeat, input logic [1:0] eresp);
      int beats = 0;
      int cyc = 0;
      int n;
      logic [5:0]  idx;
      logic [31:0] exp;
      logic [1:0]  er;
      err_beat = ebeat;
      for (int i = 0; i <= len; i++) begin
         idx = a[7:2] + 6'(i);
         exp_rd_q.push_back(ref_mem[idx]);
      end
      issue_cmd(1'b0, a, len[7:0], eresp);
      vectors++;
      if ({axi.arvalid, axi.araddr, axi.arlen, axi.awvalid} !== {1'b1, a, len[7:0], 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL ar_phase: got %h required %h",
                  {axi.arvalid, axi.araddr, axi.arlen, axi.awvalid}, {1'b1, a, len[7:0], 1'b0});
      end
      while (beats <= len && cyc < 200) begin
         rd_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
         #1;
         if (axi.rvalid) begin
            vectors++;
            if (axi.rready !== rd_ready) begin
               miscompares++;
               $display("[TB] FAIL rready_mirror: got %b required %b", axi.rready, rd_ready);
            end
         end
         if (rd_valid && rd_ready) begin
            exp = exp_rd_q.pop_front();
            vectors++;
            if ({rd_data, rd_last} !== {exp, (beats == len)}) begin
               miscompares++;
               $display("[TB] FAIL r_beat%0d: got %h/%b required %h/%b", beats,
                        rd_data, rd_last, exp, (beats == len));
            end
            beats++;
         end
         @(negedge clk);
         cyc++;
      end
      rd_ready = 1'b0;
      vectors++;
      if (beats != len + 1) begin
         miscompares++;
         $display("[TB] FAIL read_beat_count: got %0d required %0d", beats, len + 1);
      end
      n = 0;
      while (!done && n < 50) begin @(negedge clk); n++; end
      er = exp_resp_q.pop_front();
      vectors++;
      if ({done, done_resp} !== {1'b1, er}) begin
         miscompares++;
         $display("[TB] FAIL read_done: got %b required %b", {done, done_resp}, {1'b1, er});
      end
      @(negedge clk);
      vectors++;
      if ({done, rd_valid, cmd_ready} !== 3'b001) begin
         miscompares++;
         $display("[TB] FAIL read_done_once: got %b required 001", {done, rd_valid, cmd_ready});
      end
      err_beat = -1;
   endtask

   task automatic test_bad_len();
      logic [1:0] er;
      for (int k = 0; k < 2; k++) begin
         issue_cmd(k == 0, 14'h0100, (k == 0) ? 8'd255 : 8'd16, 2'b10);
         er = exp_resp_q.pop_front();
         vectors++;
         if ({done, done_resp, axi.awvalid, axi.arvalid} !== {1'b1, er, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL bad_len%0d: got %b required %b", k,
                     {done, done_resp, axi.awvalid, axi.arvalid}, {1'b1, er, 2'b00});
         end
         @(negedge clk);
         vectors++;
         if ({done, cmd_ready, axi.awvalid, axi.arvalid} !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL bad_len%0d_after: got %b required 0100", k,
                     {done, cmd_ready, axi.awvalid, axi.arvalid});
         end
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      logic [1:0] er;
      awready_en = 1'b0;
      issue_cmd(1'b1, 14'h0020, 8'd0, 2'b11);
      while (axi.awvalid && n < 100) begin n++; @(negedge clk); end
      vectors++;
      if (n != TO) begin
         miscompares++;
         $display("[TB] FAIL timeout_cycles: got %0d required %0d", n, TO);
      end
      er = exp_resp_q.pop_front();
      vectors++;
      if ({done, done_resp} !== {1'b1, er}) begin
         miscompares++;
         $display("[TB] FAIL timeout_done: got %b required %b", {done, done_resp}, {1'b1, er});
      end
      @(negedge clk);
      vectors++;
      if ({cmd_ready, done, axi.awvalid} !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL timeout_idle: got %b required 100", {cmd_ready, done, axi.awvalid});
      end
      awready_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int n;
      for (int i = 0; i < 8; i++) wbuf[i] = 32'hBEEF_0000 | i;
      issue_cmd(1'b1, 14'h0080, 8'd7, 2'b00);
      for (int i = 0; i < 2; i++) begin
         wr_valid = 1'b1; wr_data = wbuf[i];
         #1;
         n = 0;
         while (!wr_ready && n < 50) begin @(negedge clk); n++; end
         @(negedge clk);
      end
      wr_data = wbuf[2];
      rst = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if ({cmd_ready, axi.awvalid, axi.wvalid, wr_ready, axi.bready, axi.arvalid,
           axi.rready, rd_valid, done, done_resp} !== {1'b1, 10'b0}) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_outputs: got %b required %b",
                  {cmd_ready, axi.awvalid, axi.wvalid, wr_ready, axi.bready, axi.arvalid,
                   axi.rready, rd_valid, done, done_resp}, {1'b1, 10'b0});
      end
      rst = 1'b0;
      wr_valid = 1'b0;
      exp_resp_q.delete();
      @(negedge clk);
      test_read(14'h0000, 3, 1'b0, -1, 2'b00);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global_time_limit: simulation did not finish");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'hC0DE_0000 | i;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      test_reset();
      wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
      test_write(14'h0040, 3);
      test_read(14'h0040, 3, 1'b0, -1, 2'b00);
      test_read(14'h0000, 7, 1'b1, -1, 2'b00);
      test_read(14'h0010, 3, 1'b0, 1, 2'b10);
      wbuf[0] = 32'hA5A5_5A5A;
      test_write(14'h0060, 0);
      test_read(14'h0060, 0, 1'b0, -1, 2'b00);
      test_bad_len();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
